calc_entry_fsm: RTL and testbench
=================================

CALC_ENTRY_FSM -- requirements
Module: calc_entry_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 SHALL have input clk, 1 bit: the single system clock.
REQ-003 SHALL have input reset, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have input sw, WIDTH bits: operand value from the slide switches.
REQ-005 SHALL have input btn_enter, 1 bit: debounced pulse; may stay high for many clk cycles.
REQ-006 SHALL have input btn_op, 1 bit: debounced pulse that advances the opcode.
REQ-007 SHALL have input btn_clear, 1 bit: debounced pulse that aborts entry.
REQ-008 SHALL have output opcode, 2 bits: 00 add, 01 sub, 10 mul, 11 and.
REQ-009 SHALL have output state, 2 bits: 00 LOAD_A, 01 LOAD_B, 10 RESULT.
REQ-010 SHALL have output op_a, WIDTH bits: captured operand A.
REQ-011 SHALL have output op_b, WIDTH bits: captured operand B.
REQ-012 SHALL have output result, 2*WIDTH bits: registered result.
REQ-013 SHALL have output valid, 1 bit: high while result holds a completed computation.
REQ-014 SHALL have output neg, 1 bit: high when a sub result is negative.
REQ-015 SHALL have output disp_val, 2*WIDTH bits: value to show on the display.

Function
REQ-016 Each button SHALL pass through a one-register rising-edge detector; an event fires only in the first clk cycle the input is high (in & ~in_d).
REQ-017 Holding a button high SHALL generate exactly one event; a new event needs a low cycle first.
REQ-018 All state, operand, result and flag updates SHALL occur on the clk edge that samples the event cycle (1-cycle latency from the event to the visible output).
REQ-019 Event priority in the same cycle SHALL be clear > enter > op; lower-priority events in that cycle are dropped.
REQ-020 A clear event in any state SHALL force LOAD_A, zero op_a/op_b/result, and deassert valid/neg; opcode is kept.
REQ-021 In LOAD_A, an enter event SHALL capture sw into op_a and move to LOAD_B.
REQ-022 In LOAD_B, an enter event SHALL capture sw into op_b, write result and neg computed from op_a, sw and opcode, set valid=1, and move to RESULT.
REQ-023 In RESULT, an enter event SHALL move to LOAD_A and clear valid; op_a, op_b and result are retained.
REQ-024 In LOAD_A or LOAD_B, an op event SHALL increment opcode modulo 4 (11 wraps to 00).
REQ-025 In RESULT, op events SHALL be ignored.
REQ-026 add SHALL give a zero-extended A+B; the carry lands in bit WIDTH.
REQ-027 sub SHALL give (A-B) mod 2^(2*WIDTH) as two's complement; neg=1 iff A<B.
REQ-028 mul SHALL give the full unsigned 2*WIDTH product.
REQ-029 and SHALL give a zero-extended A&B.
REQ-030 neg SHALL be 0 for every opcode except sub.
REQ-031 disp_val SHALL be a zero-extended sw in LOAD_A/LOAD_B and result in RESULT; it is combinational from state.
REQ-032 State encoding 11 SHALL be unreachable; if it is entered, the next clk SHALL go to LOAD_A.

Reset
REQ-033 Asserting reset SHALL immediately set state=LOAD_A, opcode=00, op_a=op_b=0, result=0, valid=0 and neg=0.
REQ-034 Edge-detector history registers SHALL reset to 1, so a button held through reset release fires no event until it goes low and high again.
REQ-035 Reset asserted mid-entry (state LOAD_B or RESULT) SHALL discard the partial operands with no residual event.

Verification
REQ-036 Add: sw=0xC8, enter; sw=0x64, enter -> state=10, result=0x012C, valid=1, neg=0, disp_val=0x012C.
REQ-037 Sub: op pressed once (opcode=01); A=0x05, B=0x07 -> result=0xFFFE, neg=1.
REQ-038 Mul with opcode wrap: op pressed 6 times -> opcode=10; A=0xFF, B=0xFF -> result=0xFE01.
REQ-039 Held enter: btn_enter high for 50 cycles in LOAD_A -> exactly one transition to LOAD_B, op_a=sw.
REQ-040 Simultaneous events: clear+enter in the same cycle in LOAD_B -> LOAD_A, valid=0, op_b=0; enter+op in the same cycle in LOAD_A -> LOAD_B, opcode unchanged.
REQ-041 Reset with btn_enter held high -> after release, state stays LOAD_A until btn_enter drops and rises again.

Source files
------------

// File: rtl/calc_entry_fsm.sv
// calc_entry_fsm: two-operand calculator entry sequencer with edge-detected buttons
module calc_entry_fsm #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   sw,
  input  logic               btn_enter,
  input  logic               btn_op,
  input  logic               btn_clear,
  output logic [1:0]         opcode,
  output logic [1:0]         state,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] result,
  output logic               valid,
  output logic               neg,
  output logic [2*WIDTH-1:0] disp_val
);
  typedef enum logic [1:0] {LOAD_A = 2'b00, LOAD_B = 2'b01, RESULT = 2'b10, BAD = 2'b11} state_t;
  state_t st, st_n;
  logic enter_d, op_d, clear_d;
  logic ev_enter, ev_op, ev_clear;
  logic [1:0] opcode_n;
  logic [WIDTH-1:0] a_n, b_n;
  logic [2*WIDTH-1:0] res_n, ax, bx, calc;
  logic valid_n, neg_n;
  assign ev_enter = btn_enter & ~enter_d;
  assign ev_op = btn_op & ~op_d;
  assign ev_clear = btn_clear & ~clear_d;
  assign ax = {{WIDTH{1'b0}}, op_a};
  assign bx = {{WIDTH{1'b0}}, sw};
  assign calc = opcode == 2'b00 ? ax + bx :
                opcode == 2'b01 ? ax - bx :
                opcode == 2'b10 ? ax * bx : ax & bx;
  assign state = st;
  assign disp_val = st == RESULT ? result : bx;
  // history resets high so a button held through reset needs a fresh press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= LOAD_A;
      opcode <= 2'b00;
      op_a <= '0;
      op_b <= '0;
      result <= '0;
      valid <= 1'b0;
      neg <= 1'b0;
      enter_d <= 1'b1;
      op_d <= 1'b1;
      clear_d <= 1'b1;
    end else begin
      st <= st_n;
      opcode <= opcode_n;
      op_a <= a_n;
      op_b <= b_n;
      result <= res_n;
      valid <= valid_n;
      neg <= neg_n;
      enter_d <= btn_enter;
      op_d <= btn_op;
      clear_d <= btn_clear;
    end
  end
  always_comb begin
    st_n = st;
    opcode_n = opcode;
    a_n = op_a;
    b_n = op_b;
    res_n = result;
    valid_n = valid;
    neg_n = neg;
    if (ev_clear) begin
      st_n = LOAD_A;
      a_n = '0;
      b_n = '0;
      res_n = '0;
      valid_n = 1'b0;
      neg_n = 1'b0;
    end else begin
      case (st)
        LOAD_A: begin
          if (ev_enter) begin
            a_n = sw;
            st_n = LOAD_B;
          end else if (ev_op) opcode_n = opcode + 2'd1;
        end
        LOAD_B: begin
          if (ev_enter) begin
            b_n = sw;
            res_n = calc;
            neg_n = opcode == 2'b01 && op_a < sw;
            valid_n = 1'b1;
            st_n = RESULT;
          end else if (ev_op) opcode_n = opcode + 2'd1;
        end
        RESULT: begin
          if (ev_enter) begin
            st_n = LOAD_A;
            valid_n = 1'b0;
          end
        end
        default: st_n = LOAD_A;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_entry_fsm.sv
// tb_calc_entry_fsm: directed checks of entry sequencing, arithmetic and button edge handling
module tb_calc_entry_fsm;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] sw = '0;
  logic btn_enter = 1'b0, btn_op = 1'b0, btn_clear = 1'b0;
  logic [1:0] opcode, state;
  logic [7:0] op_a, op_b;
  logic [15:0] result, disp_val;
  logic valid, neg;
  int checks = 0;
  int errors = 0;
  calc_entry_fsm #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .sw(sw), .btn_enter(btn_enter), .btn_op(btn_op),
    .btn_clear(btn_clear), .opcode(opcode), .state(state), .op_a(op_a), .op_b(op_b),
    .result(result), .valid(valid), .neg(neg), .disp_val(disp_val)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // b = {clear, enter, op}; one high cycle then one low cycle
  task automatic press(input logic [2:0] b);
    {btn_clear, btn_enter, btn_op} = b;
    tick;
    {btn_clear, btn_enter, btn_op} = 3'b000;
    tick;
  endtask
  initial begin
    #2 reset = 1'b1;
    #1;
    check("rst_state", state, 2'b00);
    check("rst_opcode", opcode, 2'b00);
    check("rst_op_a", op_a, 8'h00);
    check("rst_result", result, 16'h0);
    check("rst_valid", valid, 1'b0);
    check("rst_neg", neg, 1'b0);
    tick;
    reset = 1'b0;
    tick;
    sw = 8'hC8;
    press(3'b010);
    check("add_state_b", state, 2'b01);
    check("add_op_a", op_a, 8'hC8);
    check("disp_sw", disp_val, 16'h00C8);
    sw = 8'h64;
    press(3'b010);
    check("add_state_r", state, 2'b10);
    check("add_op_b", op_b, 8'h64);
    check("add_result", result, 16'h012C);
    check("add_valid", valid, 1'b1);
    check("add_neg", neg, 1'b0);
    check("add_disp", disp_val, 16'h012C);
    press(3'b010);
    check("ret_state", state, 2'b00);
    check("ret_valid", valid, 1'b0);
    check("ret_result", result, 16'h012C);
    check("ret_disp", disp_val, 16'h0064);
    press(3'b001);
    check("sub_opcode", opcode, 2'b01);
    sw = 8'h05;
    press(3'b010);
    sw = 8'h07;
    press(3'b010);
    check("sub_result", result, 16'hFFFE);
    check("sub_neg", neg, 1'b1);
    press(3'b001);
    check("op_ignored", opcode, 2'b01);
    press(3'b100);
    check("clr_state", state, 2'b00);
    check("clr_result", result, 16'h0);
    check("clr_neg", neg, 1'b0);
    check("clr_opcode", opcode, 2'b01);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    for (int i = 0; i < 6; i++) press(3'b001);
    check("wrap_opcode", opcode, 2'b10);
    sw = 8'hFF;
    press(3'b010);
    press(3'b010);
    check("mul_result", result, 16'hFE01);
    check("mul_neg", neg, 1'b0);
    press(3'b010);
    press(3'b001);
    check("and_opcode", opcode, 2'b11);
    sw = 8'hF0;
    press(3'b010);
    sw = 8'h3C;
    press(3'b010);
    check("and_result", result, 16'h0030);
    press(3'b010);
    press(3'b001);
    check("op_wrap00", opcode, 2'b00);
    sw = 8'h5A;
    btn_enter = 1'b1;
    tick;
    sw = 8'h11;
    for (int i = 0; i < 49; i++) tick;
    btn_enter = 1'b0;
    tick;
    check("hold_state", state, 2'b01);
    check("hold_op_a", op_a, 8'h5A);
    sw = 8'h22;
    press(3'b110);
    check("ce_state", state, 2'b00);
    check("ce_valid", valid, 1'b0);
    check("ce_op_b", op_b, 8'h00);
    check("ce_op_a", op_a, 8'h00);
    sw = 8'h33;
    press(3'b011);
    check("eo_state", state, 2'b01);
    check("eo_op_a", op_a, 8'h33);
    check("eo_opcode", opcode, 2'b00);
    btn_enter = 1'b1;
    reset = 1'b1;
    #1;
    check("arst_state", state, 2'b00);
    check("arst_op_a", op_a, 8'h00);
    tick;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick;
    check("held_rst_state", state, 2'b00);
    btn_enter = 1'b0;
    tick;
    check("held_rst_low", state, 2'b00);
    press(3'b010);
    check("held_rst_repress", state, 2'b01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
